serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial addition sequencer built around a single instance of the team's 1-bit full adder (`adder1`). It accepts two N-bit operands plus carry-in over a valid/ready handshake and feeds them LSB-first through the one full adder, one bit per clock, holding the carry in a flop. It then presents the N-bit sum, carry-out and signed overflow on a second valid/ready handshake. It is the area-minimal adder path for the life-cell neighbour-count and accumulation logic, where one shared 1-bit adder replaces an N-bit ripple adder.

## Interface
Parameters:
- `N`, default 8: operand/sum width in bits; legal range N >= 1.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `i_valid`  input  1  operands on `a`, `b`, `cin` are valid.
- `i_ready`  output  1  block can accept operands; high only in IDLE.
- `a`  input  N  addend A, unsigned or two's complement.
- `b`  input  N  addend B.
- `cin`  input  1  carry into bit 0.
- `o_valid`  output  1  result valid; high only in DONE.
- `o_ready`  input  1  consumer accepts the result.
- `sum`  output  N  (a + b + cin) mod 2^N.
- `cout`  output  1  carry out of bit N-1.
- `overflow`  output  1  two's-complement overflow: carry into bit N-1 XOR carry out of bit N-1.

## Operation
- One `adder1` instance is the only arithmetic element. No `+` operator appears on operand data. A bit counter increment is allowed.
- States:
  - IDLE: `i_ready`=1. If `i_valid` is high at a rising edge, latch `a` and `b` into shift registers SA and SB, load `cin` into the carry flop, clear the bit counter, and go to RUN.
  - RUN: adder inputs are SA[0], SB[0] and the carry flop. Each edge:
    - shift the adder `s` into the MSB of the sum shift register SS, shifting SS right;
    - shift SA and SB right;
    - load the carry flop with the adder `cout`;
    - increment the counter.
  - RUN, last bit (counter == N-1): at that edge also
    - copy the completed SS into `sum` (including the final bit);
    - set `cout` to the adder `cout`;
    - set `overflow` to the carry flop XOR the adder `cout`;
    - go to DONE.
  - DONE: `o_valid`=1. If `o_ready` is high at an edge, go to IDLE.
- `sum`, `cout` and `overflow` are dedicated output registers. They change only on the RUN→DONE edge and hold their values through IDLE, RUN and DONE until the next completion.
- While in RUN or DONE, `i_valid` is ignored and operand inputs are not sampled.
- N = 1: RUN lasts one cycle; `overflow` = `cin` XOR `cout`.
- Reset mid-operation (any state): immediately return to IDLE. SA, SB, SS, carry flop and counter are cleared. No partial result is ever emitted.

## Timing
- Reset values: state IDLE, `i_ready`=1, `o_valid`=0, `sum`=0, `cout`=0, `overflow`=0. Handshakes are not taken while `rst` is low.
- `i_ready` and `o_valid` are decoded from registered state only. There is no combinational path from `i_valid` or `o_ready`.
- Latency: operands are accepted at edge E. `o_valid` rises after edge E+N, so it is first sampled high at edge E+N+1.
- With `o_ready` held high, DONE lasts exactly 1 cycle and IDLE is re-entered. Peak throughput is one add per N+2 cycles.
- Backpressure: DONE persists indefinitely while `o_ready`=0. `o_valid` and the outputs stay stable and `i_ready` stays 0.
- Counter width is ceil(log2(N)), minimum 1 bit. Bit N-1 is processed at the counter's terminal value with no wrap-around inside one transaction.

## Test plan
- Reset: assert `rst`=0 mid-cycle with no clock → `o_valid`=0, `sum`=0x00, `cout`=0, `overflow`=0, `i_ready`=1.
- Basic add, N=8: `a`=0x5A, `b`=0x33, `cin`=0 → `sum`=0x8D, `cout`=0, `overflow`=1. `o_valid` is first high exactly N+1=9 edges after the accept edge, and `i_ready`=0 throughout.
- Carry and wrap: `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1, `overflow`=0. Then `a`=0x7F, `b`=0x00, `cin`=1 → `sum`=0x80, `cout`=0, `overflow`=1.
- Backpressure: hold `o_ready`=0 for 5 cycles in DONE while toggling `i_valid` with `a`=0x11 → `o_valid`, `sum` and `cout` are constant and the new operands are not taken. Raise `o_ready` → IDLE next edge, `i_ready`=1.
- Reset mid-RUN: pulse `rst` low after bit 3 of `a`=0xFF, `b`=0xFF, `cin`=1 → IDLE, `o_valid` never asserts, outputs=0. Next add `a`=0x01, `b`=0x01, `cin`=0 → `sum`=0x02, `cout`=0, with no stale carry.
- Back-to-back with `o_ready` tied high, 100 random operand pairs, plus N=1 build → every result matches (a+b+cin) reference; spacing between accepts is exactly N+2 edges.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial N-bit adder sequencer sharing one 1-bit full adder,
// operands in and result out over valid/ready handshakes.

module adder1 (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   output logic         i_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         o_valid,
   input  logic         o_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         overflow
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;

   logic [N-1:0]  sa, sb, ss, ss_nx;
   logic [CW-1:0] cnt;
   logic          c, s, co, last;

   adder1 u_add (.a(sa[0]), .b(sb[0]), .cin(c), .s(s), .cout(co));

   assign last  = (cnt == LAST);
   // new bit enters at the MSB so the LSB-first stream lands in place after N shifts
   assign ss_nx = N'({s, ss} >> 1);

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_nx;

   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE:    state_nx = i_valid ? RUN : IDLE;
         RUN:     state_nx = last ? DONE : RUN;
         DONE:    state_nx = o_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      i_ready = (state == IDLE);
      o_valid = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         sa       <= '0;
         sb       <= '0;
         ss       <= '0;
         c        <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (state == IDLE && i_valid) begin
         sa  <= a;
         sb  <= b;
         c   <= cin;
         cnt <= '0;
      end else if (state == RUN) begin
         ss  <= ss_nx;
         sa  <= sa >> 1;
         sb  <= sb >> 1;
         c   <= co;
         cnt <= cnt + 1'b1;
         if (last) begin
            sum      <= ss_nx;
            cout     <= co;
            overflow <= c ^ co;
         end
      end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for the N=8 and N=1 builds of serial_adder_ctrl.

module tb_serial_adder_ctrl;
   logic       clk = 1'b0, rst = 1'b1;
   logic       i_valid = 1'b0, o_ready = 1'b1, cin = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       i_ready, o_valid, cout, overflow;
   logic [7:0] sum;
   logic       v1 = 1'b0, r1 = 1'b1, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
   logic       ir1, ov1, s1, co1, of1;

   int pass_cnt = 0, total = 0, cyc = 0;
   logic [9:0] q8[$];
   logic [2:0] q1[$];

   serial_adder_ctrl #(.N(8)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .a(a), .b(b), .cin(cin),
      .o_valid(o_valid), .o_ready(o_ready), .sum(sum), .cout(cout), .overflow(overflow));

   serial_adder_ctrl #(.N(1)) dut1 (
      .clk(clk), .rst(rst), .i_valid(v1), .i_ready(ir1), .a(a1), .b(b1), .cin(c1),
      .o_valid(ov1), .o_ready(r1), .sum(s1), .cout(co1), .overflow(of1));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // reference: {sum, cout, overflow}; overflow by the sign rule
   function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
      logic [8:0] f;
      f = {1'b0, x} + {1'b0, y} + {8'b0, c};
      return {f[7:0], f[8], (x[7] == y[7]) && (f[7] != x[7])};
   endfunction

   function automatic logic [2:0] model1(input logic x, input logic y, input logic c);
      logic [1:0] f;
      f = {1'b0, x} + {1'b0, y} + {1'b0, c};
      return {f[0], f[1], c ^ f[1]};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic c);
      a = x; b = y; cin = c; i_valid = 1'b1;
      q8.push_back(model8(x, y, c));
      tick;
      i_valid = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!o_valid && n < 40) begin
         tick;
         n++;
      end
   endtask

   task automatic test_reset;
      #2 rst = 1'b0;
      #1;
      total++; if (o_valid !== 1'b0) $display("FAIL reset_o_valid got=%b exp=0", o_valid); else pass_cnt++;
      total++; if (sum !== 8'h00) $display("FAIL reset_sum got=%h exp=00", sum); else pass_cnt++;
      total++; if (cout !== 1'b0) $display("FAIL reset_cout got=%b exp=0", cout); else pass_cnt++;
      total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else pass_cnt++;
      total++; if (i_ready !== 1'b1) $display("FAIL reset_i_ready got=%b exp=1", i_ready); else pass_cnt++;
      total++; if ({ir1, ov1} !== 2'b10) $display("FAIL reset_n1 got=%b exp=10", {ir1, ov1}); else pass_cnt++;
      tick;
      tick;
      rst = 1'b1;
      tick;
   endtask

   task automatic test_basic;
      int   lat = 0;
      logic busy_ok = 1'b1;
      logic [9:0] exp;
      send(8'h5A, 8'h33, 1'b0);
      while (!o_valid && lat < 40) begin
         if (i_ready) busy_ok = 1'b0;
         tick;
         lat++;
      end
      total++; if (lat != 8) $display("FAIL basic_latency got=%0d exp=8 edges after accept", lat); else pass_cnt++;
      total++; if (!busy_ok) $display("FAIL basic_i_ready_busy got=1 exp=0"); else pass_cnt++;
      exp = q8.pop_front();
      total++; if ({o_valid, sum, cout, overflow} !== {1'b1, exp})
         $display("FAIL basic_result got=%b_%h_%b_%b exp=1_%h_%b_%b", o_valid, sum, cout, overflow, exp[9:2], exp[1], exp[0]);
      else pass_cnt++;
      total++; if (exp !== {8'h8D, 1'b0, 1'b1}) $display("FAIL basic_model got=%h exp=8D/0/1", exp); else pass_cnt++;
      tick;
      total++; if ({i_ready, o_valid} !== 2'b10) $display("FAIL basic_done_one_cycle got=%b exp=10", {i_ready, o_valid}); else pass_cnt++;
   endtask

   task automatic test_carry;
      int n;
      logic [9:0] exp;
      send(8'hFF, 8'h01, 1'b0);
      wait_out(n);
      exp = q8.pop_front();
      total++; if ({o_valid, sum, cout, overflow} !== {1'b1, 8'h00, 1'b1, 1'b0} || exp !== {8'h00, 1'b1, 1'b0})
         $display("FAIL carry_wrap got=%b_%h_%b_%b exp=1_00_1_0", o_valid, sum, cout, overflow);
      else pass_cnt++;
      tick;
      send(8'h7F, 8'h00, 1'b1);
      wait_out(n);
      exp = q8.pop_front();
      total++; if ({o_valid, sum, cout, overflow} !== {1'b1, exp})
         $display("FAIL carry_cin_ovf got=%b_%h_%b_%b exp=1_%h_%b_%b", o_valid, sum, cout, overflow, exp[9:2], exp[1], exp[0]);
      else pass_cnt++;
      tick;
   endtask

   task automatic test_backpressure;
      int n;
      logic [9:0] exp, snap;
      o_ready = 1'b0;
      send(8'h90, 8'h90, 1'b0);
      wait_out(n);
      exp = q8.pop_front();
      total++; if ({o_valid, sum, cout, overflow} !== {1'b1, exp})
         $display("FAIL bp_result got=%b_%h_%b_%b exp=1_%h_%b_%b", o_valid, sum, cout, overflow, exp[9:2], exp[1], exp[0]);
      else pass_cnt++;
      snap = {sum, cout, overflow};
      for (int i = 0; i < 5; i++) begin
         i_valid = ~i_valid;
         a = 8'h11; b = 8'h11;
         tick;
         total++; if ({o_valid, i_ready, sum, cout, overflow} !== {2'b10, snap})
            $display("FAIL bp_hold_%0d got=%b%b_%h exp=10_%h", i, o_valid, i_ready, {sum, cout, overflow}, snap);
         else pass_cnt++;
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      tick;
      total++; if ({i_ready, o_valid, sum, cout, overflow} !== {2'b10, snap})
         $display("FAIL bp_release got=%b%b_%h exp=10_%h", i_ready, o_valid, {sum, cout, overflow}, snap);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      int   n;
      logic seen = 1'b0;
      logic [9:0] exp;
      send(8'hFF, 8'hFF, 1'b1);
      void'(q8.pop_back());
      repeat (4) tick;
      #2 rst = 1'b0;
      #1;
      total++; if ({i_ready, o_valid, sum, cout, overflow} !== {2'b10, 10'b0})
         $display("FAIL midrst_clear got=%b%b_%h_%b_%b exp=10_00_0_0", i_ready, o_valid, sum, cout, overflow);
      else pass_cnt++;
      tick;
      rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (o_valid) seen = 1'b1;
         tick;
      end
      total++; if (seen || !i_ready) $display("FAIL midrst_no_output got=o_valid_seen:%b i_ready:%b exp=0/1", seen, i_ready); else pass_cnt++;
      send(8'h01, 8'h01, 1'b0);
      wait_out(n);
      exp = q8.pop_front();
      total++; if ({o_valid, sum, cout, overflow} !== {1'b1, exp} || exp !== {8'h02, 2'b00})
         $display("FAIL midrst_next_add got=%b_%h_%b_%b exp=1_02_0_0", o_valid, sum, cout, overflow);
      else pass_cnt++;
      tick;
   endtask

   task automatic test_back_to_back;
      int accepts = 0, results = 0, last_acc = -1;
      logic [9:0] exp;
      o_ready = 1'b1;
      for (int k = 0; k < 3000 && results < 100; k++) begin
         if (o_valid) begin
            exp = q8.pop_front();
            total++; if ({sum, cout, overflow} !== exp)
               $display("FAIL b2b_result_%0d got=%h_%b_%b exp=%h_%b_%b", results, sum, cout, overflow, exp[9:2], exp[1], exp[0]);
            else pass_cnt++;
            results++;
         end
         if (i_ready) begin
            if (accepts < 100) begin
               a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
               i_valid = 1'b1;
               q8.push_back(model8(a, b, cin));
               if (last_acc >= 0) begin
                  total++; if (cyc + 1 - last_acc != 10) $display("FAIL b2b_spacing got=%0d exp=10", cyc + 1 - last_acc); else pass_cnt++;
               end
               last_acc = cyc + 1;
               accepts++;
            end else i_valid = 1'b0;
         end
         tick;
      end
      i_valid = 1'b0;
      total++; if (results != 100) $display("FAIL b2b_count got=%0d exp=100", results); else pass_cnt++;
      tick;
      tick;
   endtask

   task automatic test_n1;
      int accepts = 0, results = 0, last_acc = -1;
      logic [2:0] exp;
      for (int k = 0; k < 500 && results < 40; k++) begin
         if (ov1) begin
            exp = q1.pop_front();
            total++; if ({s1, co1, of1} !== exp) $display("FAIL n1_result_%0d got=%b exp=%b", results, {s1, co1, of1}, exp); else pass_cnt++;
            results++;
         end
         if (ir1) begin
            if (accepts < 40) begin
               a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
               v1 = 1'b1;
               q1.push_back(model1(a1, b1, c1));
               if (last_acc >= 0) begin
                  total++; if (cyc + 1 - last_acc != 3) $display("FAIL n1_spacing got=%0d exp=3", cyc + 1 - last_acc); else pass_cnt++;
               end
               last_acc = cyc + 1;
               accepts++;
            end else v1 = 1'b0;
         end
         tick;
      end
      v1 = 1'b0;
      total++; if (results != 40) $display("FAIL n1_count got=%0d exp=40", results); else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_carry;
      test_backpressure;
      test_reset_mid;
      test_back_to_back;
      test_n1;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
